bus_arbiter: RTL

//  Two-master arbiter for the shared data bus feeding bus_controller, RAM and GPIO.
//  M0 = CPU core load/store port; M1 = secondary master (DMA/debug loader).

---
 rtl/bus_pkg.sv | 13 +
 rtl/bus_arbiter_if.sv | 47 ++++
 rtl/rd_tag_pipe.sv | 36 +++
 rtl/bus_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master data bus arbiter: master IDs,
// the read encoding of the byte-enable field and default bus widths.
package bus_pkg;

    typedef logic id_t;

    localparam id_t        ID_M0      = 1'b0;
    localparam id_t        ID_M1      = 1'b1;
    localparam logic [3:0] WE_READ    = 4'b0000;
    localparam int         BUS_ADDR_W = 32;
    localparam int         BUS_DATA_W = 32;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the two master request/response ports plus the shared slave bus.
// The slave modport is the arbiter; the master modport is the masters and slaves around it.
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic [3:0]        m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [3:0]        m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              bus_re;
    logic [3:0]        bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output bus_re, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  bus_re, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/rd_tag_pipe.sv
// Delay line of {valid,id} read tags; the output stage lines up with bus_rdata.
// Reset drops every outstanding tag.
module rd_tag_pipe
    import bus_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  id_t  in_id,
    output logic out_vld,
    output id_t  out_id
);

    logic [RD_LATENCY-1:0] vld_pipe;
    id_t  [RD_LATENCY-1:0] id_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            id_pipe[0]  <= in_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[RD_LATENCY-1];
    assign out_id  = id_pipe[RD_LATENCY-1];

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a burst cap. Grant is combinational
// on the live requests; read data is steered back to its owner via a tag pipe.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W     = BUS_ADDR_W,
    parameter int DATA_W     = BUS_DATA_W,
    parameter int MAX_BURST  = 4,
    parameter int RD_LATENCY = 1
) (
    input logic           clk,
    input logic           rst_n,
    bus_arbiter_if.slave  bif
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [1:0]             req;
    logic [1:0][3:0]        we;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;

    id_t              last_owner;
    logic [CNT_W-1:0] beat_cnt;
    logic             has_win;
    id_t              winner;
    logic             out_vld;
    id_t              out_id;

    assign req   = {bif.m1_req,   bif.m0_req};
    assign we    = {bif.m1_we,    bif.m0_we};
    assign addr  = {bif.m1_addr,  bif.m0_addr};
    assign wdata = {bif.m1_wdata, bif.m0_wdata};

    // beat_cnt==0 means no burst is running, so the first contention after
    // reset or an idle cycle goes away from last_owner (M0 after reset).
    always_comb begin
        has_win = 1'b0;
        winner  = ID_M0;
        if (rst_n && |req) begin
            has_win = 1'b1;
            if (&req)
                winner = (beat_cnt != '0 && beat_cnt < CNT_MAX) ? last_owner : ~last_owner;
            else
                winner = req[1] ? ID_M1 : ID_M0;
        end
    end

    assign bif.m0_gnt    = has_win && (winner == ID_M0);
    assign bif.m1_gnt    = has_win && (winner == ID_M1);
    assign bif.bus_re    = has_win && (we[winner] == WE_READ);
    assign bif.bus_we    = has_win ? we[winner]    : '0;
    assign bif.bus_addr  = has_win ? addr[winner]  : '0;
    assign bif.bus_wdata = has_win ? wdata[winner] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= ID_M1;
            beat_cnt   <= '0;
        end else if (has_win) begin
            last_owner <= winner;
            if (winner == last_owner)
                beat_cnt <= (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_W'(1);
            else
                beat_cnt <= CNT_W'(1);
        end else begin
            beat_cnt <= '0;
        end
    end

    rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (bif.bus_re),
        .in_id   (winner),
        .out_vld (out_vld),
        .out_id  (out_id)
    );

    assign bif.m0_rvalid = out_vld && (out_id == ID_M0);
    assign bif.m1_rvalid = out_vld && (out_id == ID_M1);
    assign bif.m0_rdata  = bif.m0_rvalid ? bif.bus_rdata : '0;
    assign bif.m1_rdata  = bif.m1_rvalid ? bif.bus_rdata : '0;

endmodule
